// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard with branch/jump redirect kill window.
// Optional performance counters are built when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int ALU_LAT     = 3,
    parameter int LOAD_LAT    = 4,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwen,
    input  logic              id_is_load,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic [2:0]        ex_funct3,
    input  logic              br_eq,
    input  logic              br_lt,
    output logic              stall,
    output logic              id_ex_bubble,
    output logic              issue,
    output logic              branch_taken,
    output logic              flush,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    localparam logic [CNT_W-1:0] ALU_LAT_C   = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_LAT_C  = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] KILL_INIT_C = CNT_W'(FLUSH_DEPTH - 1);

    logic [CNT_W-1:0]    sb_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    kill_cnt_reg;
    logic [CNT_W-1:0]    write_lat;
    logic                cond;
    logic                taken;
    logic                kill;
    logic                haz;

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:         cond = br_eq;
            3'b001:         cond = ~br_eq;
            3'b100, 3'b110: cond = br_lt;
            3'b101, 3'b111: cond = ~br_lt;
            default:        cond = 1'b0;
        endcase
    end

    assign taken        = ex_valid & (ex_is_jump | (ex_is_branch & cond));
    assign branch_taken = taken;
    assign flush        = taken;
    assign kill         = taken | (kill_cnt_reg != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kill_cnt_reg <= '0;
        end else if (taken) begin
            kill_cnt_reg <= KILL_INIT_C;
        end else if (kill_cnt_reg != '0) begin
            kill_cnt_reg <= kill_cnt_reg - 1'b1;
        end
    end

    // Hazard check sees pre-update counters, so rs==rd issues on a clear entry.
    assign haz = id_valid & ((id_use_rs1 & (id_rs1 != '0) & busy[id_rs1]) |
                             (id_use_rs2 & (id_rs2 != '0) & busy[id_rs2]));

    always_comb begin
        stall        = 1'b0;
        id_ex_bubble = 1'b0;
        issue        = 1'b0;
        if (kill) begin
            id_ex_bubble = 1'b1;
        end else begin
            stall        = haz;
            id_ex_bubble = haz;
            issue        = id_valid & ~haz;
        end
    end

    assign write_lat = id_is_load ? LOAD_LAT_C : ALU_LAT_C;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        sb_reg[gi] <= '0;
                    end else begin
                        sb_reg[gi] <= '0;
                    end
                end
                assign busy[gi] = 1'b0;
            end else begin : g_reg
                logic [CNT_W-1:0] dec_val;
                logic [CNT_W-1:0] sb_next;
                logic             wr_hit;

                assign wr_hit  = issue & id_regwen & (id_rd == REG_AW'(gi));
                assign dec_val = (sb_reg[gi] == '0) ? '0 : sb_reg[gi] - 1'b1;
                // A younger write never shortens an older, longer pending write.
                assign sb_next = wr_hit ? ((dec_val > write_lat) ? dec_val : write_lat)
                                        : dec_val;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        sb_reg[gi] <= '0;
                    end else begin
                        sb_reg[gi] <= sb_next;
                    end
                end
                assign busy[gi] = (sb_reg[gi] != '0);
            end
        end
    endgenerate

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall) stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (flush) flush_count_reg  <= flush_count_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (ALU_LAT=3, LOAD_LAT=4, FLUSH_DEPTH=3).
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_regwen, id_is_load;
    logic        ex_valid, ex_is_branch, ex_is_jump;
    logic [2:0]  ex_funct3;
    logic        br_eq, br_lt;
    logic        stall, id_ex_bubble, issue, branch_taken, flush;
    logic [31:0] stall_cycles, flush_count;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_scoreboard #(
        .NUM_REGS(32), .REG_AW(5), .ALU_LAT(3), .LOAD_LAT(4),
        .FLUSH_DEPTH(3), .CNT_W(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwen(id_regwen), .id_is_load(id_is_load),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_funct3(ex_funct3), .br_eq(br_eq), .br_lt(br_lt),
        .stall(stall), .id_ex_bubble(id_ex_bubble), .issue(issue),
        .branch_taken(branch_taken), .flush(flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check stall / id_ex_bubble / issue / flush as one transaction.
    task automatic chk_out(input string tag, input logic s, input logic b,
                           input logic i, input logic f);
        $display("step %s: stall=%0b bubble=%0b issue=%0b flush=%0b taken=%0b",
                 tag, stall, id_ex_bubble, issue, flush, branch_taken);
        chk({tag, ".stall"},  {31'd0, stall},        {31'd0, s});
        chk({tag, ".bubble"}, {31'd0, id_ex_bubble}, {31'd0, b});
        chk({tag, ".issue"},  {31'd0, issue},        {31'd0, i});
        chk({tag, ".flush"},  {31'd0, flush},        {31'd0, f});
        chk({tag, ".taken"},  {31'd0, branch_taken}, {31'd0, f});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_regwen = 0; id_is_load = 0;
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_funct3 = 0;
        br_eq = 0; br_lt = 0;
    endtask

    task automatic set_writer(input logic [4:0] rd, input logic ld);
        idle();
        id_valid = 1; id_regwen = 1; id_rd = rd; id_is_load = ld;
    endtask

    task automatic set_reader(input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
        idle();
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    initial begin
        idle();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #4;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.stall_cycles", stall_cycles, 32'd0);
        chk("reset.flush_count",  flush_count,  32'd0);
        @(posedge clk); #1;
        reset_n = 1;
        tick();

        // ALU dependence: write x5, reader stalls 3 cycles.
        set_writer(5'd5, 0);
        #1 chk_out("alu_wr", 0, 0, 1, 0);
        tick();
        set_reader(5'd5, 1, 5'd0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk_out("alu_stall", 1, 1, 0, 0);
            tick();
        end
        #1 chk_out("alu_issue", 0, 0, 1, 0);
        tick();

        // Taken JAL, then two more kill cycles with a killed writer of x6.
        idle();
        ex_valid = 1; ex_is_jump = 1;
        #1 chk_out("jal", 0, 1, 0, 1);
        tick();
        set_writer(5'd6, 0);
        for (int k = 0; k < 2; k++) begin
            #1 chk_out("jal_kill", 0, 1, 0, 0);
            tick();
        end
        set_reader(5'd6, 1, 5'd6, 1);
        #1 chk_out("killed_wr_x6", 0, 0, 1, 0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk("perf.stall_cycles", stall_cycles, 32'd3);
        chk("perf.flush_count",  flush_count,  32'd1);
`else
        chk("perf.stall_cycles", stall_cycles, 32'd0);
        chk("perf.flush_count",  flush_count,  32'd0);
`endif
        tick();

        // Load dependence on rs2: 4 stall cycles; rs1=x0-only variant never stalls.
        set_writer(5'd7, 1);
        #1 chk_out("ld_wr", 0, 0, 1, 0);
        tick();
        set_reader(5'd0, 1, 5'd7, 0);
        #1 chk_out("ld_x0_only", 0, 0, 1, 0);
        set_reader(5'd0, 0, 5'd7, 1);
        for (int k = 0; k < 4; k++) begin
            #1 chk_out("ld_stall", 1, 1, 0, 0);
            tick();
        end
        #1 chk_out("ld_issue", 0, 0, 1, 0);
        tick();

        // x0 writes are never tracked.
        set_writer(5'd0, 0);
        tick();
        set_reader(5'd0, 1, 5'd0, 1);
        #1 chk_out("x0_read", 0, 0, 1, 0);
        tick();

        // WAW: load x3 then ALU x3 -> max(3,3)=3 stall cycles.
        set_writer(5'd3, 1);
        tick();
        set_writer(5'd3, 0);
        #1 chk("waw_alu_issue", {31'd0, issue}, 32'd1);
        tick();
        set_reader(5'd3, 1, 5'd0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk_out("waw_stall", 1, 1, 0, 0);
            tick();
        end
        #1 chk_out("waw_issue", 0, 0, 1, 0);
        tick();

        // Self-dependence: rs1==rd issues on a clear entry, then sets it.
        set_writer(5'd9, 0);
        id_rs1 = 5'd9; id_use_rs1 = 1;
        #1 chk_out("self_issue", 0, 0, 1, 0);
        tick();
        set_reader(5'd9, 1, 5'd0, 0);
        #1 chk_out("self_next", 1, 1, 0, 0);
        tick(); tick(); tick();

        // Redirect overriding a hazard: BNE not-equal with reader of x5 pending.
        set_writer(5'd5, 0);
        tick();
        set_reader(5'd5, 1, 5'd0, 0);
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b001; br_eq = 0;
        #1 chk_out("bne_taken", 0, 1, 0, 1);
        tick();
        set_reader(5'd5, 1, 5'd0, 0);
        for (int k = 0; k < 2; k++) begin
            #1 chk_out("bne_kill", 0, 1, 0, 0);
            tick();
        end
        #1 chk_out("bne_after", 0, 0, 1, 0);
        tick();

        // Combinational-only branch decode checks (inputs cleared before the edge).
        idle();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b001; br_eq = 1;
        #1 chk_out("bne_eq", 0, 0, 0, 0);
        ex_funct3 = 3'b010; br_eq = 1; br_lt = 1;
        #1 chk_out("f3_010", 0, 0, 0, 0);
        ex_funct3 = 3'b101; br_lt = 0;
        #1 chk_out("bge", 0, 1, 0, 1);
        ex_funct3 = 3'b110; br_lt = 1;
        #1 chk_out("bltu", 0, 1, 0, 1);
        idle();
        ex_valid = 0; ex_is_jump = 1;
        #1 chk_out("ex_bubble_jump", 0, 0, 0, 0);
        idle();
        tick();

        // Reset mid-stall with sb[5]=2.
        set_writer(5'd5, 0);
        tick();
        set_reader(5'd5, 1, 5'd0, 0);
        tick();
        #1 chk_out("pre_rst_stall", 1, 1, 0, 0);
        reset_n = 0;
        #1 chk("rst_mid.stall", {31'd0, stall}, 32'd0);
        chk("rst_mid.stall_cycles", stall_cycles, 32'd0);
        tick();
        reset_n = 1;
        #1 chk_out("post_rst_issue", 0, 0, 1, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-type hazard detector for the non-forwarding RV32I pipeline.
- Replaces the single stall counter and opcode matching with a per-register scoreboard:
  - a pending-write countdown for each architectural register;
  - per-class write latencies;
  - branch/jump redirect with a configurable front-end kill depth.
- Sits beside the ID stage: gates ID→EX issue, injects bubbles, and flushes IF/ID on redirects resolved in EX.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- REG_AW, 5, register index width.
- ALU_LAT, 3, cycles from issue until a non-load result is readable in ID (1..2^CNT_W-1).
- LOAD_LAT, 4, cycles from issue until a load result is readable in ID (>= ALU_LAT).
- FLUSH_DEPTH, 1, cycles of issue suppression following a redirect, counting the redirect cycle (1..2^CNT_W-1).
- CNT_W, 3, scoreboard counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_use_rs1, id_use_rs2  in  1  instruction reads the corresponding source.
- id_rd  in  REG_AW  destination register.
- id_regwen  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_is_branch, ex_is_jump  in  1  EX instruction class.
- ex_funct3  in  3  branch condition.
- br_eq, br_lt  in  1  comparator results (signed or unsigned per funct3, selected upstream).
- stall  out  1  hold PC and IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- issue  out  1  the ID instruction advances into EX this cycle.
- branch_taken  out  1  select the EX target PC.
- flush  out  1  kill IF/ID contents.
- stall_cycles  out  32  performance counter (see Optional Feature).
- flush_count  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All scoreboard counters and kill_cnt cleared to 0.
  - Perf counters cleared to 0.
  - With id_valid=0, every output reads 0.
- Redirect decode (combinational):
  - taken = ex_valid & (ex_is_jump | (ex_is_branch & cond)).
  - cond by funct3: 000 eq; 001 !eq; 100/110 lt; 101/111 !lt; 010/011 → 0.
  - branch_taken = flush = taken.
- Kill window:
  - On taken, kill_cnt <= FLUSH_DEPTH-1.
  - Otherwise kill_cnt decrements while nonzero.
  - kill = taken | (kill_cnt != 0).
- Hazard (combinational):
  - haz = id_valid & ((id_use_rs1 & rs1!=0 & sb[rs1]!=0) | (id_use_rs2 & rs2!=0 & sb[rs2]!=0)).
- Output priority:
  - Kill first: stall=0, issue=0, id_ex_bubble=1.
  - Otherwise stall = haz, id_ex_bubble = haz, issue = id_valid & !haz.
- Scoreboard update, every clock, for each r≠0:
  - If issue & id_regwen & id_rd==r: sb[r] <= max(sb[r]-sat, lat), where lat = id_is_load ? LOAD_LAT : ALU_LAT.
  - Else if sb[r]!=0: sb[r] <= sb[r]-1.
  - sb[0] is held at 0.
- A source whose counter equals 1 still stalls; it becomes readable the following cycle (WB-before-ID write-through).
- Self-dependence (rs1==rd): the hazard check uses the pre-update counter. The instruction issues if that counter is 0 and then sets its own entry.
- Killed instructions never write the scoreboard. Entries from already-issued older instructions are unaffected by a flush.
- Back-to-back redirects: a new taken during the kill window reloads kill_cnt.

Optional Feature:
- Macro HAZARD_SCOREBOARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with stall=1.
  - flush_count increments on every cycle with flush=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset mid-stall: reset_n low while sb[5]=2 → stall=0, all counters 0 next cycle; an instruction reading x5 issues immediately.
- ALU dependence (ALU_LAT=3): issue write x5, then reader of x5 held in ID → stall=1 and id_ex_bubble=1 for 3 cycles, issue=1 on the 4th.
- Load dependence (LOAD_LAT=4): load x7, then reader of x7 with id_use_rs2 only → 4 stall cycles. The same reader with id_use_rs2=0 and rs1=x0 → 0 stalls.
- x0 and WAW: write x0, then read x0 → no stall. Load x3, next cycle ALU write x3 → sb[3]=max(3,3)=3, then decrements to 0.
- Redirect: BNE in EX with br_eq=0 and ex_valid=1 while ID has a hazard → flush=1, branch_taken=1, stall=0, issue=0. With FLUSH_DEPTH=3, issue stays 0 for 2 more cycles. BNE with br_eq=1 → no flush. Bubble in EX (ex_valid=0) with ex_is_jump=1 → no flush.
- Perf (HAZARD_SCOREBOARD_PERF_EN defined): the ALU-dependence case followed by one taken JAL → stall_cycles=3, flush_count=1. Without the macro, both outputs read 0.
